// File: rtl/sb_packet_rx.sv
// sb_packet_rx
// Byte-serial receiver and deframer for sideband packets of the form
//   START(A5) Type Size Data[Size] Error END(5A)
// Accepted bytes (in_valid && in_ready) step a single FSM that captures
// the header, payload and error byte, keeps a running XOR checksum and
// presents the finished packet on a valid/ready output.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_byte    incoming serial byte
//   in_valid   in_byte is valid
//   in_ready   receiver accepts a byte this cycle (low only while holding a packet)
//   pkt_valid  assembled packet is presented
//   pkt_ready  consumer takes the packet
//   pkt_type   Header.Type
//   pkt_size   Header.Size (number of data bytes)
//   pkt_data   payload, byte i in [8i+7:8i], unused bytes zero
//   pkt_error  received Error byte
//   pkt_chk_ok received Error byte equals the computed XOR checksum
//   drop_cnt   malformed frames dropped, saturating at 8'hFF
module sb_packet_rx #(
  parameter logic [7:0] START_BYTE     = 8'hA5,
  parameter logic [7:0] END_BYTE       = 8'h5A,
  parameter int         MAX_DATA_BYTES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_byte,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [7:0]                    pkt_type,
  output logic [7:0]                    pkt_size,
  output logic [MAX_DATA_BYTES*8-1:0]   pkt_data,
  output logic [7:0]                    pkt_error,
  output logic                          pkt_chk_ok,
  output logic [7:0]                    drop_cnt
);

  localparam int         IDX_W = (MAX_DATA_BYTES > 1) ? $clog2(MAX_DATA_BYTES) : 1;
  localparam logic [7:0] MAX_B = 8'(MAX_DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_TYPE, S_SIZE, S_DATA, S_ERR, S_END, S_HOLD
  } state_t;

  state_t                        r_state;
  logic                          r_in_ready;
  logic                          r_pkt_valid;
  logic [7:0]                    r_type;
  logic [7:0]                    r_size;
  logic [MAX_DATA_BYTES*8-1:0]   r_data;
  logic [7:0]                    r_err;
  logic [7:0]                    r_csum;
  logic                          r_chk_ok;
  logic [7:0]                    r_drop;
  logic [IDX_W-1:0]              r_idx;

  logic                          w_accept;
  logic [7:0]                    w_idx_ext;

  assign w_accept  = in_valid && r_in_ready;
  assign w_idx_ext = 8'(r_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_pkt_valid <= 1'b0;
      r_type      <= '0;
      r_size      <= '0;
      r_data      <= '0;
      r_err       <= '0;
      r_csum      <= '0;
      r_chk_ok    <= 1'b0;
      r_drop      <= '0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Anything other than START while hunting is ignored and not counted.
          if (w_accept && in_byte == START_BYTE) begin
            r_state <= S_TYPE;
            r_csum  <= '0;
            r_data  <= '0;
          end
        end
        S_TYPE: begin
          if (w_accept) begin
            r_type  <= in_byte;
            r_csum  <= r_csum ^ in_byte;
            r_state <= S_SIZE;
          end
        end
        S_SIZE: begin
          if (w_accept) begin
            r_size <= in_byte;
            r_csum <= r_csum ^ in_byte;
            if (in_byte != 8'd0 && in_byte <= MAX_B) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              r_state <= S_IDLE;
              if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_data[{r_idx, 3'b000} +: 8] <= in_byte;
            r_csum                       <= r_csum ^ in_byte;
            r_idx                        <= r_idx + 1'b1;
            if (w_idx_ext == r_size - 8'd1) r_state <= S_ERR;
          end
        end
        S_ERR: begin
          if (w_accept) begin
            r_err   <= in_byte;
            r_state <= S_END;
          end
        end
        S_END: begin
          if (w_accept) begin
            if (in_byte == END_BYTE) begin
              // Checksum verdict is registered with pkt_valid so both appear together.
              r_state     <= S_HOLD;
              r_pkt_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_chk_ok    <= (r_csum == r_err);
            end else begin
              r_state <= S_IDLE;
              if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            end
          end
        end
        S_HOLD: begin
          // in_ready returns one cycle after the handshake: no comb path from pkt_ready.
          if (pkt_ready) begin
            r_state     <= S_IDLE;
            r_pkt_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_pkt_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign pkt_valid  = r_pkt_valid;
  assign pkt_type   = r_type;
  assign pkt_size   = r_size;
  assign pkt_data   = r_data;
  assign pkt_error  = r_err;
  assign pkt_chk_ok = r_chk_ok;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_sb_packet_rx.sv
// Testbench for sb_packet_rx: scoreboard of expected packets filled as
// frames are built, drained by a monitor at each packet handshake.
module tb_sb_packet_rx;

  typedef struct {
    logic [7:0]  t;
    logic [7:0]  s;
    logic [63:0] d;
    logic [7:0]  e;
    logic        ok;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic [7:0]  pkt_type;
  logic [7:0]  pkt_size;
  logic [63:0] pkt_data;
  logic [7:0]  pkt_error;
  logic        pkt_chk_ok;
  logic [7:0]  drop_cnt;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_seen = 0;
  pkt_t sb[$];
  logic [7:0] frm[$];

  sb_packet_rx dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_type(pkt_type), .pkt_size(pkt_size), .pkt_data(pkt_data),
    .pkt_error(pkt_error), .pkt_chk_ok(pkt_chk_ok), .drop_cnt(drop_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic monitor();
    pkt_t ex;
    forever begin
      @(negedge clk);
      if (rst_n && pkt_valid && pkt_ready) begin
        n_seen++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pkt type=%02h size=%02h, none expected", pkt_type, pkt_size);
        end else begin
          ex = sb.pop_front();
          if (pkt_type !== ex.t) begin n_fail++; $display("FAIL pkt_type got %02h want %02h", pkt_type, ex.t); end
          n_cmp++;
          if (pkt_size !== ex.s) begin n_fail++; $display("FAIL pkt_size got %02h want %02h", pkt_size, ex.s); end
          n_cmp++;
          if (pkt_data !== ex.d) begin n_fail++; $display("FAIL pkt_data got %016h want %016h", pkt_data, ex.d); end
          n_cmp++;
          if (pkt_error !== ex.e) begin n_fail++; $display("FAIL pkt_error got %02h want %02h", pkt_error, ex.e); end
          n_cmp++;
          if (pkt_chk_ok !== ex.ok) begin n_fail++; $display("FAIL pkt_chk_ok got %b want %b", pkt_chk_ok, ex.ok); end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    in_byte = b;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout byte=%02h in_ready=%b want 1", b, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frm[i]) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_byte = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_byte(frm[i]);
    end
    frm.delete();
  endtask

  // Appends a well-framed packet to frm and, if asked, the expected result to the scoreboard.
  task automatic queue_frame(input logic [7:0] t, input logic [7:0] s, input logic [63:0] d,
                             input logic [7:0] e, input bit expect_pkt);
    logic [7:0] chk;
    pkt_t       ex;
    frm.push_back(8'hA5);
    frm.push_back(t);
    frm.push_back(s);
    chk = t ^ s;
    for (int i = 0; i < int'(s); i++) begin
      frm.push_back(d[8*i +: 8]);
      chk = chk ^ d[8*i +: 8];
    end
    frm.push_back(e);
    frm.push_back(8'h5A);
    if (expect_pkt) begin
      ex.t = t; ex.s = s; ex.d = d; ex.e = e; ex.ok = (chk == e);
      sb.push_back(ex);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_valid got %b want 0", pkt_valid); end
    n_cmp++; if (pkt_type !== 8'h00) begin n_fail++; $display("FAIL rst_type got %02h want 00", pkt_type); end
    n_cmp++; if (pkt_size !== 8'h00) begin n_fail++; $display("FAIL rst_size got %02h want 00", pkt_size); end
    n_cmp++; if (pkt_data !== 64'h0) begin n_fail++; $display("FAIL rst_data got %016h want 0", pkt_data); end
    n_cmp++; if (pkt_error !== 8'h00) begin n_fail++; $display("FAIL rst_error got %02h want 00", pkt_error); end
    n_cmp++; if (pkt_chk_ok !== 1'b0) begin n_fail++; $display("FAIL rst_chk_ok got %b want 0", pkt_chk_ok); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_drop got %02h want 00", drop_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int pulses;
    do_reset();
    pkt_ready = 1'b1;
    queue_frame(8'h01, 8'h02, 64'h2211, 8'h30, 1'b1);
    send_frame(1'b0);
    n_cmp++; if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL nom_latency pkt_valid got %b want 1", pkt_valid); end
    pulses = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (pkt_valid) pulses++;
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL nom_valid_cycles got %0d want 1", pulses); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nom_in_ready got %b want 1", in_ready); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL nom_drop got %02h want 00", drop_cnt); end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL nom_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    pkt_ready = 1'b0;
    queue_frame(8'h07, 8'h08, 64'h0807_0605_0403_0201, 8'h07, 1'b1);
    send_frame(1'b0);
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", pkt_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      n_cmp++; if (pkt_data !== 64'h0807_0605_0403_0201) begin n_fail++; $display("FAIL bp_data got %016h want 0807060504030201", pkt_data); end
      n_cmp++; if (pkt_chk_ok !== 1'b1) begin n_fail++; $display("FAIL bp_chk_ok got %b want 1", pkt_chk_ok); end
      @(posedge clk); #1;
    end
    pkt_ready = 1'b1;
    wait_drain();
    n_cmp++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", pkt_valid); end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    queue_frame(8'h01, 8'h02, 64'h2211, 8'hFF, 1'b1);
    send_frame(1'b0);
    wait_drain();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL badchk_pending got %0d want 0", sb.size()); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL badchk_drop got %02h want 00", drop_cnt); end
  endtask

  task automatic test_framing();
    int seen0;
    do_reset();
    seen0 = n_seen;
    frm.push_back(8'hA5); frm.push_back(8'h01); frm.push_back(8'h00);
    frm.push_back(8'hA5); frm.push_back(8'h01); frm.push_back(8'h09);
    queue_frame(8'h01, 8'h02, 64'h2211, 8'h30, 1'b0);
    frm[frm.size()-1] = 8'h00;
    send_frame(1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (n_seen != seen0) begin n_fail++; $display("FAIL frm_no_pkt got %0d want 0", n_seen - seen0); end
    n_cmp++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL frm_drop got %02h want 03", drop_cnt); end
    queue_frame(8'h01, 8'h02, 64'h2211, 8'h30, 1'b1);
    send_frame(1'b0);
    wait_drain();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL frm_recover got %0d want 0", sb.size()); end
    n_cmp++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL frm_drop_after got %02h want 03", drop_cnt); end
  endtask

  task automatic test_hunt_gaps();
    do_reset();
    frm.push_back(8'h00); frm.push_back(8'hFF); frm.push_back(8'h5A);
    queue_frame(8'h01, 8'h02, 64'h2211, 8'h30, 1'b1);
    send_frame(1'b1);
    wait_drain();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL hunt_pending got %0d want 0", sb.size()); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL hunt_drop got %02h want 00", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Second frame carries A5 as type and as data: no mid-frame resync.
    queue_frame(8'h5A, 8'h03, 64'hA5_3C11, 8'hD1, 1'b1);
    queue_frame(8'hA5, 8'h01, 64'hA5, 8'h00, 1'b1);
    send_frame(1'b0);
    wait_drain();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid_and_sat();
    do_reset();
    queue_frame(8'h01, 8'h02, 64'h2211, 8'h30, 1'b1);
    send_frame(1'b0);
    wait_drain();
    frm.push_back(8'hA5); frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h11);
    send_frame(1'b0);
    do_reset();
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    n_cmp++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", pkt_valid); end
    n_cmp++; if (pkt_type !== 8'h00) begin n_fail++; $display("FAIL mid_type got %02h want 00", pkt_type); end
    n_cmp++; if (pkt_size !== 8'h00) begin n_fail++; $display("FAIL mid_size got %02h want 00", pkt_size); end
    n_cmp++; if (pkt_data !== 64'h0) begin n_fail++; $display("FAIL mid_data got %016h want 0", pkt_data); end
    n_cmp++; if (pkt_error !== 8'h00) begin n_fail++; $display("FAIL mid_error got %02h want 00", pkt_error); end
    n_cmp++; if (pkt_chk_ok !== 1'b0) begin n_fail++; $display("FAIL mid_chk_ok got %b want 0", pkt_chk_ok); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL mid_drop got %02h want 00", drop_cnt); end
    @(posedge clk); #1;
    queue_frame(8'h01, 8'h02, 64'h2211, 8'h30, 1'b1);
    send_frame(1'b0);
    wait_drain();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL mid_recover got %0d want 0", sb.size()); end
    for (int f = 0; f < 300; f++) begin
      frm.push_back(8'hA5); frm.push_back(8'h01); frm.push_back(8'h00);
      send_frame(1'b0);
      if (f == 253) begin
        n_cmp++; if (drop_cnt !== 8'hFE) begin n_fail++; $display("FAIL sat_pre got %02h want FE", drop_cnt); end
      end
    end
    n_cmp++; if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_drop got %02h want FF", drop_cnt); end
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_nominal();
    test_backpressure();
    test_bad_checksum();
    test_framing();
    test_hunt_gaps();
    test_back_to_back();
    test_reset_mid_and_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_packet_rx.md
# sb_packet_rx

Byte-serial receiver and deframer for the sideband packet format (Start, Header{Type, Size}, Data, Error, End). It accepts one byte per handshake from the link, checks the framing, and assembles the fields into a parallel packet. It validates a checksum and presents the packet on a valid/ready output to the cache/MESI control logic. It is the receiving end of the byte-serial sideband transmitter.

## Interface
- START_BYTE, 8'hA5, framing byte that opens a packet
- END_BYTE, 8'h5A, framing byte that closes a packet
- MAX_DATA_BYTES, 8, maximum data payload in bytes; the data output is MAX_DATA_BYTES*8 = 64 bits
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_byte  in  8  incoming serial byte
- in_valid  in  1  in_byte is valid
- in_ready  out  1  the receiver accepts in_byte this cycle
- pkt_valid  out  1  an assembled packet is presented
- pkt_ready  in  1  the consumer takes the packet
- pkt_type  out  8  Header.Type
- pkt_size  out  8  Header.Size, the number of data bytes
- pkt_data  out  64  Data field; byte i sits in [8i+7:8i]; unused bytes are 0
- pkt_error  out  8  the received Error byte
- pkt_chk_ok  out  1  the received Error byte equals the computed checksum
- drop_cnt  out  8  number of malformed frames dropped; saturates at 8'hFF

## Operation
- An input byte is accepted when in_valid && in_ready.
- States and transitions, each taken on an accepted byte:
  - IDLE:
    - byte == START_BYTE -> TYPE.
    - any other byte is discarded silently; drop_cnt does not change.
  - TYPE: store the byte as type -> SIZE.
  - SIZE: store the byte as size.
    - size in 1..MAX_DATA_BYTES -> DATA, with the byte index cleared to 0.
    - otherwise -> IDLE and drop_cnt++.
  - DATA: write the byte into data[8*idx +: 8] and increment idx.
    - when idx == size-1 -> ERR.
  - ERR: store the byte as err -> END.
  - END:
    - byte == END_BYTE -> HOLD.
    - otherwise -> IDLE and drop_cnt++.
  - HOLD: pkt_valid = 1; when pkt_ready = 1 -> IDLE.
- Checksum:
  - The running XOR is cleared on START acceptance.
  - It accumulates the Type, Size and every Data byte.
  - pkt_chk_ok = (checksum == err).
  - A packet with a bad checksum is still delivered, with pkt_chk_ok = 0; it is not counted as a drop.
- The data register is cleared to 0 on START acceptance, so unused upper bytes read as 0.
- drop_cnt increments by one per dropped frame and holds at 8'hFF.
- A START_BYTE value arriving in TYPE, SIZE, DATA or ERR is treated as ordinary data. There is no resync mid-frame.

## Timing
- Reset (rst_n = 0 at a clock edge) has these results:
  - state = IDLE.
  - in_ready = 1 and pkt_valid = 0.
  - pkt_type, pkt_size, pkt_error, pkt_data and drop_cnt all = 0.
  - pkt_chk_ok = 0.
- Reset mid-frame abandons the frame without incrementing drop_cnt.
- in_ready = 1 in every state except HOLD, where it is 0.
- in_ready is a registered function of state. There is no combinational path from pkt_ready to in_ready.
- pkt_valid rises in the cycle after the END byte is accepted.
- The pkt_* outputs are stable while pkt_valid = 1 and !pkt_ready.
- When pkt_ready is sampled high with pkt_valid, the state is IDLE next cycle. That gives a minimum one-cycle input bubble per packet.
- A frame of N data bytes takes N+5 accepted bytes.
- Best-case throughput is one packet per N+6 cycles.
- in_valid gaps may occur in any state. The FSM holds its state, and there is no timeout.
- pkt_chk_ok is registered together with pkt_valid. There is no extra latency.

## Test plan
- Nominal frame:
  - Stimulus: A5 01 02 11 22 30 5A, back-to-back, pkt_ready = 1.
  - Response: pkt_valid for 1 cycle, the cycle after 5A.
  - Fields: type = 01, size = 02, data = 64'h0000_0000_0000_2211, error = 30, chk_ok = 1, drop_cnt = 0.
- Full payload with backpressure:
  - Stimulus: A5 07 08, then bytes 01..08, then checksum 07^08^(01^..^08) = 07, then 5A. pkt_ready is held 0 for 5 cycles.
  - Response: pkt_valid and the fields hold steady, in_ready = 0 throughout.
  - data = 64'h0807_0605_0403_0201, chk_ok = 1.
- Bad checksum:
  - Stimulus: the nominal frame with error byte FF.
  - Response: the packet is delivered with chk_ok = 0; drop_cnt = 0.
- Framing faults:
  - Stimulus: size 00, then size 09, then a frame ending in 00 instead of 5A.
  - Response: no pkt_valid; drop_cnt = 3.
  - A following nominal frame is received correctly.
- Hunt and idle gaps:
  - Stimulus: 00 FF 5A precede a frame; in_valid is toggled randomly within the frame.
  - Response: the leading bytes are ignored without counting; the frame decodes as in the nominal case.
- Reset mid-frame and saturation:
  - Stimulus: rst_n low for 1 cycle after the DATA byte 11.
  - Response: all outputs return to their reset values, and the next frame decodes.
  - Stimulus: 300 bad-size frames.
  - Response: drop_cnt = FF.
